instr_sequencer: RTL



---
 rtl/instr_sequencer_pkg.sv | 18 +
 rtl/instr_sequencer_perf_counters.sv | 29 ++
 rtl/instr_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared state encoding, opcode constants and instruction-class helpers for instr_sequencer.
package seq_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} seq_state_t;

  localparam logic [2:0]  FC_LOAD    = 3'b100;
  localparam logic [2:0]  FC_STORE   = 3'b110;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  function automatic logic is_mem_op(logic [31:0] instr);
    return (instr[17:15] == FC_LOAD) || (instr[17:15] == FC_STORE);
  endfunction

  function automatic logic is_store(logic [31:0] instr);
    return instr[17:15] == FC_STORE;
  endfunction

endpackage

// File: rtl/instr_sequencer_perf_counters.sv
// Saturating busy-cycle and retired-instruction counters, used only when SEQ_PERF_CNT_EN is defined.
module seq_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        busy_i,
  input  logic        retire_i,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] retired_cnt_o
);

  logic [1:0] inc;
  assign inc = {retire_i, busy_i};

  // Index 0 counts busy cycles, index 1 counts retirements; both stick at all-ones.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [31:0] cnt_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (inc[gi] && (cnt_q != 32'hFFFF_FFFF)) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign cycle_cnt_o   = g_cnt[0].cnt_q;
  assign retired_cnt_o = g_cnt[1].cnt_q;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning pc and ir_q.
// Define SEQ_PERF_CNT_EN to add the cycle_cnt / retired_cnt performance counters.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ir_q,
  output logic              alu_en,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic              rf_we,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       retired_cnt
`endif
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  seq_state_t        state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              imem_req_q, alu_en_q, dmem_req_q, dmem_we_q, rf_we_q, busy_q, halted_q;

  // Outputs are registered alongside the state: each transition loads the
  // output values belonging to the destination state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      imem_req_q <= 1'b0;
      alu_en_q   <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      alu_en_q <= 1'b0;
      rf_we_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= FETCH;
            imem_req_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            ir_q       <= imem_rdata;
            imem_req_q <= 1'b0;
            state_q    <= DECODE;
          end
        end
        DECODE: begin
          if (ir_q == HALT_INSTR) begin
            state_q  <= HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q  <= EXEC;
            alu_en_q <= 1'b1;
          end
        end
        EXEC: begin
          if (is_mem_op(ir_q)) begin
            state_q    <= MEM;
            dmem_req_q <= 1'b1;
            dmem_we_q  <= is_store(ir_q);
          end else begin
            state_q <= WB;
            rf_we_q <= 1'b1;
          end
        end
        MEM: begin
          if (dmem_ack) begin
            state_q    <= WB;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= !is_store(ir_q);
          end
        end
        WB: begin
          pc_q       <= pc_q + PC_ONE;
          state_q    <= FETCH;
          imem_req_q <= 1'b1;
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign alu_en    = alu_en_q;
  assign dmem_req  = dmem_req_q;
  assign dmem_we   = dmem_we_q;
  assign rf_we     = rf_we_q;
  assign busy      = busy_q;
  assign halted    = halted_q;

`ifdef SEQ_PERF_CNT_EN
  logic retire;
  assign retire = (state_q == WB) || ((state_q == DECODE) && (ir_q == HALT_INSTR));

  seq_perf_counters u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .busy_i       (busy_q),
    .retire_i     (retire),
    .cycle_cnt_o  (cycle_cnt),
    .retired_cnt_o(retired_cnt)
  );
`endif

endmodule
